// File: rtl/lap_recall.sv
// Lap-time capture/recall stage: live BCD time pass-through, circular lap buffer, oldest-first recall.
// Latency: 1 cycle registered outputs; no backpressure (buttons are level inputs, edge-detected).
module lap_recall #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lap,
    input  logic          recall,
    input  logic          clear,
    input  logic [7:0]    centisec_in,
    input  logic [7:0]    sec_in,
    input  logic [7:0]    min_in,
    input  logic [7:0]    hour_in,
    output logic [7:0]    centisec_out,
    output logic [7:0]    sec_out,
    output logic [7:0]    min_out,
    output logic [7:0]    hour_out,
    output logic [AW:0]   lap_count,
    output logic          recall_active,
    output logic [AW:0]   recall_idx,
    output logic          full
);

    typedef enum logic {S_LIVE, S_RECALL} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t        r_state, w_state_nxt;
    logic [AW:0]   r_count, w_count_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_base, w_base_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic          r_lap_h, r_rec_h, r_clr_h;
    logic          w_wr_en;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   w_live;
    logic [31:0]   w_disp;
    logic [AW-1:0] w_rd_addr;
    logic          w_lap_ev, w_rec_ev, w_clr_ev;

    assign w_lap_ev = lap & ~r_lap_h;
    assign w_rec_ev = recall & ~r_rec_h;
    assign w_clr_ev = clear & ~r_clr_h;
    assign w_live   = {hour_in, min_in, sec_in, centisec_in};

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_base_nxt   = r_base;
        w_idx_nxt    = r_idx;
        w_wr_en      = 1'b0;
        if (w_clr_ev) begin
            w_state_nxt  = S_LIVE;
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_base_nxt   = '0;
            w_idx_nxt    = '0;
        end else if (w_lap_ev) begin
            if (r_state == S_LIVE) begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                // A full buffer drops its oldest entry, so the window start advances.
                if (r_count == DEPTH_C) begin
                    w_base_nxt = r_base + 1'b1;
                end else begin
                    w_count_nxt = r_count + ONE_C;
                end
            end
        end else if (w_rec_ev) begin
            if (r_state == S_LIVE) begin
                if (r_count != '0) begin
                    w_state_nxt = S_RECALL;
                    w_idx_nxt   = '0;
                end
            end else if ({1'b0, r_idx} == r_count - ONE_C) begin
                w_state_nxt = S_LIVE;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Lap writes and recall entry never coincide, so the read sees settled memory.
    assign w_rd_addr = w_base_nxt + w_idx_nxt;
    assign w_disp    = (w_state_nxt == S_RECALL) ? r_mem[w_rd_addr] : w_live;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_live;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_LIVE;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_base        <= '0;
            r_idx         <= '0;
            r_lap_h       <= 1'b1;
            r_rec_h       <= 1'b1;
            r_clr_h       <= 1'b1;
            hour_out      <= '0;
            min_out       <= '0;
            sec_out       <= '0;
            centisec_out  <= '0;
            recall_active <= 1'b0;
            recall_idx    <= '0;
            full          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_base        <= w_base_nxt;
            r_idx         <= w_idx_nxt;
            r_lap_h       <= lap;
            r_rec_h       <= recall;
            r_clr_h       <= clear;
            {hour_out, min_out, sec_out, centisec_out} <= w_disp;
            recall_active <= (w_state_nxt == S_RECALL);
            recall_idx    <= (w_state_nxt == S_RECALL) ? ({1'b0, w_idx_nxt} + ONE_C) : '0;
            full          <= (w_count_nxt == DEPTH_C);
        end
    end

    assign lap_count = r_count;

endmodule

// File: tb/tb_lap_recall.sv
// Scoreboard bench for lap_recall: queue-based lap model predicts each cycle's outputs.
module tb_lap_recall;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        lap, recall, clear;
    logic [7:0]  centisec_in, sec_in, min_in, hour_in;
    logic [7:0]  centisec_out, sec_out, min_out, hour_out;
    logic [AW:0] lap_count, recall_idx;
    logic        recall_active, full;

    always #5 clk = ~clk;

    lap_recall #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .lap(lap), .recall(recall), .clear(clear),
        .centisec_in(centisec_in), .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .centisec_out(centisec_out), .sec_out(sec_out), .min_out(min_out), .hour_out(hour_out),
        .lap_count(lap_count), .recall_active(recall_active), .recall_idx(recall_idx), .full(full)
    );

    typedef struct {
        logic [31:0] t;
        int          cnt;
        logic        act;
        int          idx;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_laps[$];
    bit          m_rec;
    int          m_idx;
    bit          p_l, p_r, p_c;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_laps.delete();
        m_rec = 1'b0;
        m_idx = 0;
        p_l = 1'b1; p_r = 1'b1; p_c = 1'b1;
    endtask

    task automatic step(input logic l, input logic r, input logic c, input logic [31:0] t);
        bit   el, er, ec;
        exp_t e;
        @(negedge clk);
        rst    = 1'b0;
        lap    = l;
        recall = r;
        clear  = c;
        {hour_in, min_in, sec_in, centisec_in} = t;
        el = l && !p_l; er = r && !p_r; ec = c && !p_c;
        p_l = l; p_r = r; p_c = c;
        if (ec) begin
            m_laps.delete();
            m_rec = 1'b0;
            m_idx = 0;
        end else if (el) begin
            if (!m_rec) begin
                m_laps.push_back(t);
                if (m_laps.size() > DEPTH) void'(m_laps.pop_front());
            end
        end else if (er) begin
            if (!m_rec) begin
                if (m_laps.size() > 0) begin
                    m_rec = 1'b1;
                    m_idx = 0;
                end
            end else if (m_idx < m_laps.size() - 1) begin
                m_idx++;
            end else begin
                m_rec = 1'b0;
                m_idx = 0;
            end
        end
        e.t    = m_rec ? m_laps[m_idx] : t;
        e.cnt  = m_laps.size();
        e.act  = m_rec;
        e.idx  = m_rec ? m_idx + 1 : 0;
        e.full = (m_laps.size() == DEPTH);
        sb.push_back(e);
    endtask

    task automatic press(input bit is_lap, input logic [31:0] t);
        step(is_lap, !is_lap, 1'b0, t);
        step(1'b0, 1'b0, 1'b0, t);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_time"}, {hour_out, min_out, sec_out, centisec_out}, 32'h0);
        check({tag, "_count"}, 32'(lap_count), 32'h0);
        check({tag, "_active"}, 32'(recall_active), 32'h0);
        check({tag, "_idx"}, 32'(recall_idx), 32'h0);
        check({tag, "_full"}, 32'(full), 32'h0);
    endtask

    // Monitor: one expected record per clock once stimulus is flowing.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("time_out", {hour_out, min_out, sec_out, centisec_out}, e.t);
                check("lap_count", 32'(lap_count), 32'(e.cnt));
                check("recall_active", 32'(recall_active), 32'(e.act));
                check("recall_idx", 32'(recall_idx), 32'(e.idx));
                check("full", 32'(full), 32'(e.full));
            end
        end
    end

    initial begin
        lap = 1'b0; recall = 1'b0; clear = 1'b0;
        {hour_in, min_in, sec_in, centisec_in} = 32'h0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        model_reset();

        // Pass-through
        step(1'b0, 1'b0, 1'b0, 32'h01234567);
        step(1'b0, 1'b0, 1'b0, 32'h01234567);

        // Capture three laps, recall through them and back to live
        press(1'b1, 32'h00000110);
        press(1'b1, 32'h00000220);
        press(1'b1, 32'h00000330);
        for (int i = 0; i < 4; i++) press(1'b0, 32'h00000400 + 32'(i));

        // Overflow: ten laps, oldest two dropped
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) press(1'b1, 32'h00000000 + 32'(i));
        for (int i = 0; i < 9; i++) press(1'b0, 32'h00005900);

        // Ignored events
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        press(1'b0, 32'h00001111);
        press(1'b1, 32'h00001200);
        press(1'b1, 32'h00001300);
        press(1'b0, 32'h00001400);
        press(1'b1, 32'h00001500);
        press(1'b0, 32'h00001600);
        press(1'b0, 32'h00001700);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 32'h00002000 + 32'(i));
        step(1'b0, 1'b0, 1'b0, 32'h00002100);

        // Simultaneous events
        step(1'b1, 1'b1, 1'b0, 32'h00003000);
        step(1'b0, 1'b0, 1'b0, 32'h00003001);
        step(1'b1, 1'b0, 1'b1, 32'h00003100);
        step(1'b0, 1'b0, 1'b0, 32'h00003101);

        // Async reset while recalling the second lap
        press(1'b1, 32'h00004001);
        press(1'b1, 32'h00004002);
        press(1'b1, 32'h00004003);
        press(1'b0, 32'h00004100);
        press(1'b0, 32'h00004200);
        @(negedge clk);
        #2 rst = 1'b1;
        lap = 1'b0; recall = 1'b0; clear = 1'b0;
        #1 check_zero_outputs("async_rst");
        repeat (2) @(negedge clk);
        model_reset();
        step(1'b0, 1'b0, 1'b0, 32'h12345678);
        step(1'b0, 1'b0, 1'b0, 32'h23456789);

        // Random buttons and live time
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 24) == 0, $urandom);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
